// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU instruction sequencer: opcodes, FSM states,
// the instruction word layout and small decode helpers.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_SFL = 4'h2,
    OP_SFR = 4'h3,
    OP_INC = 4'h4,
    OP_DEC = 4'h5,
    OP_BNE = 4'h6,
    OP_BEQ = 4'h7,
    OP_BLT = 4'h8,
    OP_LHB = 4'h9,
    OP_JMP = 4'hA
  } opcode_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs2;
    logic [7:0] imm8;
  } instr_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

  // Arithmetic/shift ops and LHB produce a register result; branches and JMP do not.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SFL, OP_SFR, OP_INC, OP_DEC, OP_LHB};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small architectural register file: two combinational operand reads,
// one combinational debug read and one synchronous write port.
module alu_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1_i,
  output logic [DATA_W-1:0]           rdata1_o,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2_i,
  output logic [DATA_W-1:0]           rdata2_o,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel_i,
  output logic [DATA_W-1:0]           dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // NOTE: this array is small and must read as zero after reset, so it is
  // built from flops with an async clear rather than inferred as a RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = regs_q[raddr1_i];
  assign rdata2_o   = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external 8-bit ALU:
// fetch, decode, execute, writeback; one instruction retires per 4+ cycles.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [15:0]       imem_rdata_i,
  input  logic              imem_valid_i,
  output logic [3:0]        alu_inst_o,
  output logic [DATA_W-1:0] alu_reg1_o,
  output logic [DATA_W-1:0] alu_reg2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_over_flag_i,
  input  logic              alu_branch_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              retire_o,
  output logic              carry_o,
  output logic [PC_W-1:0]   pc_o,
  input  logic [1:0]        dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              br_q, br_d;
  logic              ovf_q, ovf_d;
  logic              carry_q, carry_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

  alu_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (rf_we),
    .waddr_i   (IDX_W'(instr_q.rd)),
    .wdata_i   (res_q),
    .raddr1_i  (IDX_W'(instr_q.rd)),
    .rdata1_o  (rf_rdata1),
    .raddr2_i  (IDX_W'(instr_q.rs2)),
    .rdata2_o  (rf_rdata2),
    .dbg_sel_i (IDX_W'(dbg_sel_i)),
    .dbg_data_o(dbg_data_o)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    res_d      = res_q;
    br_d       = br_q;
    ovf_d      = ovf_q;
    carry_d    = carry_q;
    rf_we      = 1'b0;
    imem_req_o = 1'b0;
    alu_inst_o = '0;
    alu_reg1_o = '0;
    alu_reg2_o = '0;

    unique case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_valid_i) begin
          instr_d = instr_t'(imem_rdata_i);
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = op_is_illegal(instr_q.op) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        alu_inst_o = instr_q.op;
        // LHB loads its immediate through the ALU's first operand.
        alu_reg1_o = (instr_q.op == OP_LHB) ? DATA_W'(instr_q.imm8) : rf_rdata1;
        alu_reg2_o = rf_rdata2;
        res_d      = alu_result_i;
        br_d       = alu_branch_i;
        ovf_d      = alu_over_flag_i;
        state_d    = WRITEBACK;
      end
      WRITEBACK: begin
        rf_we = op_writes_reg(instr_q.op);
        if (instr_q.op == OP_ADD) begin
          carry_d = ovf_q;
        end
        pc_d    = br_q ? PC_W'(instr_q.imm8) : pc_q + 1'b1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign carry_o     = carry_q;
  assign busy_o      = state_q inside {FETCH, DECODE, EXECUTE, WRITEBACK};
  assign halted_o    = (state_q == HALT);
  assign retire_o    = (state_q == WRITEBACK);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU and instruction
// memory, vector table, directed corner sequences and a random-program model.
module tb_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic [15:0] imem_rdata_i;
  logic        imem_valid_i;
  logic [3:0]  alu_inst_o;
  logic [7:0]  alu_reg1_o, alu_reg2_o;
  logic [7:0]  alu_result_i;
  logic        alu_over_flag_i;
  logic        alu_branch_i;
  logic        busy_o, halted_o, retire_o, carry_o;
  logic [7:0]  pc_o;
  logic [1:0]  dbg_sel_i;
  logic [7:0]  dbg_data_o;

  alu_sequencer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .imem_valid_i   (imem_valid_i),
    .alu_inst_o     (alu_inst_o),
    .alu_reg1_o     (alu_reg1_o),
    .alu_reg2_o     (alu_reg2_o),
    .alu_result_i   (alu_result_i),
    .alu_over_flag_i(alu_over_flag_i),
    .alu_branch_i   (alu_branch_i),
    .busy_o         (busy_o),
    .halted_o       (halted_o),
    .retire_o       (retire_o),
    .carry_o        (carry_o),
    .pc_o           (pc_o),
    .dbg_sel_i      (dbg_sel_i),
    .dbg_data_o     (dbg_data_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 0;
  logic [15:0] imem [256];

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // External ALU behaviour as seen from the sequencer.
  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       br;
  } alu_out_t;

  function automatic alu_out_t alu_model(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    alu_out_t o;
    int s;
    o = '0;
    case (op)
      4'h0: begin s = int'(a) + int'(b); o.res = 8'(s); o.ovf = (s > 255); end
      4'h1: o.res = 8'(int'(a) - int'(b));
      4'h2: o.res = 8'(int'(a) << b[2:0]);
      4'h3: o.res = a >> b[2:0];
      4'h4: o.res = 8'(int'(a) + 1);
      4'h5: o.res = 8'(int'(a) - 1);
      4'h6: o.br = (a != b);
      4'h7: o.br = (a == b);
      4'h8: o.br = (a < b);
      4'h9: o.res = a;
      4'hA: o.br = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  alu_out_t alu_now;
  always_comb begin
    alu_now         = alu_model(alu_inst_o, alu_reg1_o, alu_reg2_o);
    alu_result_i    = alu_now.res;
    alu_over_flag_i = alu_now.ovf;
    alu_branch_i    = alu_now.br;
  end

  // Instruction memory: answers a request after `lat` waiting cycles.
  initial begin
    int fcnt;
    fcnt         = 0;
    imem_valid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (imem_req_o) begin
        if (fcnt >= lat) begin
          imem_valid_i = 1'b1;
          imem_rdata_i = imem[imem_addr_o];
        end
        fcnt++;
      end else begin
        fcnt         = 0;
        imem_valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    dbg_sel_i = 2'(idx);
    #1;
    v = dbg_data_o;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Waits for a retire pulse (bounded), records its cycle, then steps into FETCH.
  task automatic run_to_retire(input string name, output int at_cyc);
    int budget;
    budget = 200;
    while (!retire_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) check({name, "_retire_timeout"}, 32'd0, 32'd1);
    at_cyc = cyc;
    @(negedge clk_i);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs2, input logic [7:0] imm);
    return {op, rd, rs2, imm};
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r0;
    logic [7:0] exp_pc;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [15];

  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_carry;

  // Architectural reference: one whole instruction applied to the model state.
  task automatic model_step(input logic [15:0] w);
    logic [3:0] op;
    logic [7:0] a, imm;
    alu_out_t   o;
    op  = w[15:12];
    imm = w[7:0];
    a   = (op == 4'h9) ? imm : m_r[w[11:10]];
    o   = alu_model(op, a, m_r[w[9:8]]);
    if (op <= 4'h5 || op == 4'h9) m_r[w[11:10]] = o.res;
    if (op == 4'h0) m_carry = o.ovf;
    m_pc = o.br ? imm : 8'(m_pc + 8'd1);
  endtask

  initial begin
    logic [7:0] v;
    int t [3];
    int seen;
    dbg_sel_i = '0;
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    clear_imem();

    vecs[0]  = '{4'h0, 8'h70, 8'h90, 8'h00, 8'h03, 1'b1};
    vecs[1]  = '{4'h0, 8'h12, 8'h34, 8'h46, 8'h03, 1'b0};
    vecs[2]  = '{4'h1, 8'h50, 8'h20, 8'h30, 8'h03, 1'b0};
    vecs[3]  = '{4'h1, 8'h10, 8'h20, 8'hF0, 8'h03, 1'b0};
    vecs[4]  = '{4'h2, 8'h81, 8'h01, 8'h02, 8'h03, 1'b0};
    vecs[5]  = '{4'h3, 8'h81, 8'h03, 8'h10, 8'h03, 1'b0};
    vecs[6]  = '{4'h4, 8'hFF, 8'h00, 8'h00, 8'h03, 1'b0};
    vecs[7]  = '{4'h5, 8'h00, 8'h00, 8'hFF, 8'h03, 1'b0};
    vecs[8]  = '{4'h7, 8'h05, 8'h05, 8'h05, 8'h80, 1'b0};
    vecs[9]  = '{4'h7, 8'h05, 8'h06, 8'h05, 8'h03, 1'b0};
    vecs[10] = '{4'h6, 8'h05, 8'h06, 8'h05, 8'h80, 1'b0};
    vecs[11] = '{4'h8, 8'h03, 8'hC8, 8'h03, 8'h80, 1'b0};
    vecs[12] = '{4'h8, 8'hC8, 8'h03, 8'hC8, 8'h03, 1'b0};
    vecs[13] = '{4'hA, 8'h11, 8'h22, 8'h11, 8'h80, 1'b0};
    vecs[14] = '{4'h9, 8'h11, 8'h22, 8'h80, 8'h03, 1'b0};

    // Reset state, and no activity without start_i.
    repeat (2) @(negedge clk_i);
    check("rst_pc", pc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_alu", {alu_inst_o, alu_reg1_o, alu_reg2_o}, 0);
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      check($sformatf("rst_r%0d", i), v, 0);
    end
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_req", imem_req_o, 0);

    // Vector table: LHB r0,a; LHB r1,b; OP r0,r1,0x80.
    for (int k = 0; k < 15; k++) begin
      do_reset();
      clear_imem();
      imem[0] = mk(4'h9, 2'd0, 2'd0, vecs[k].a);
      imem[1] = mk(4'h9, 2'd1, 2'd0, vecs[k].b);
      imem[2] = mk(vecs[k].op, 2'd0, 2'd1, 8'h80);
      pulse_start();
      for (int i = 0; i < 3; i++) run_to_retire($sformatf("vec%0d", k), t[i]);
      read_reg(0, v);
      check($sformatf("vec%0d_r0", k), v, vecs[k].exp_r0);
      read_reg(1, v);
      check($sformatf("vec%0d_r1", k), v, vecs[k].b);
      check($sformatf("vec%0d_pc", k), pc_o, vecs[k].exp_pc);
      check($sformatf("vec%0d_carry", k), carry_o, vecs[k].exp_carry);
    end

    // Program with carry and retire spacing.
    do_reset();
    clear_imem();
    imem[0] = 16'h94F0;
    imem[1] = 16'h9020;
    imem[2] = 16'h0400;
    pulse_start();
    for (int i = 0; i < 3; i++) run_to_retire("prog", t[i]);
    read_reg(1, v);
    check("prog_r1", v, 8'h10);
    read_reg(0, v);
    check("prog_r0", v, 8'h20);
    check("prog_carry", carry_o, 1);
    check("prog_gap1", t[1] - t[0], 4);
    check("prog_gap2", t[2] - t[1], 4);

    // Branches on r2 == r3 == 0.
    do_reset();
    clear_imem();
    imem[8'h00] = 16'h7B40;
    imem[8'h40] = 16'h6B40;
    pulse_start();
    run_to_retire("beq", t[0]);
    check("beq_pc", pc_o, 8'h40);
    run_to_retire("bne", t[0]);
    check("bne_pc", pc_o, 8'h41);

    // PC wrap after JMP to 0xFF.
    do_reset();
    clear_imem();
    imem[8'h00] = 16'hA0FF;
    imem[8'hFF] = 16'h4000;
    pulse_start();
    run_to_retire("jmp", t[0]);
    check("jmp_pc", pc_o, 8'hFF);
    run_to_retire("wrap", t[0]);
    read_reg(0, v);
    check("wrap_r0", v, 8'h01);
    check("wrap_pc", pc_o, 8'h00);

    // Illegal opcode halts without retiring, then restart at 0.
    do_reset();
    clear_imem();
    imem[0] = 16'h9855;
    imem[1] = 16'hC000;
    pulse_start();
    run_to_retire("pre_ill", t[0]);
    seen = 0;
    for (int i = 0; i < 10 && !halted_o; i++) begin
      @(negedge clk_i);
      if (retire_o) seen++;
    end
    check("ill_halted", halted_o, 1);
    check("ill_no_retire", seen, 0);
    check("ill_busy", busy_o, 0);
    check("ill_pc", pc_o, 8'h01);
    read_reg(2, v);
    check("ill_r2", v, 8'h55);
    pulse_start();
    check("restart_req", imem_req_o, 1);
    check("restart_addr", imem_addr_o, 8'h00);
    check("restart_halted", halted_o, 0);

    // Fetch stall: request and address held while memory is slow.
    do_reset();
    clear_imem();
    lat = 3;
    imem[0] = 16'h9C77;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_req", i), imem_req_o, 1);
      check($sformatf("stall%0d_addr", i), imem_addr_o, 8'h00);
      @(negedge clk_i);
    end
    run_to_retire("stall", t[0]);
    read_reg(3, v);
    check("stall_r3", v, 8'h77);
    lat = 0;

    // Reset during EXECUTE of ADD aborts it.
    do_reset();
    clear_imem();
    imem[0] = 16'h94F0;
    imem[1] = 16'h9020;
    imem[2] = 16'h0400;
    pulse_start();
    for (int i = 0; i < 2; i++) run_to_retire("abort", t[i]);
    repeat (2) @(negedge clk_i);
    check("abort_in_exec", {alu_reg1_o, alu_reg2_o}, 16'hF020);
    rst_ni = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
    read_reg(1, v);
    check("abort_r1", v, 0);
    check("abort_carry", carry_o, 0);
    check("abort_pc", pc_o, 0);
    check("abort_busy", busy_o, 0);

    // Random legal programs against the architectural model.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      lat = int'($urandom_range(0, 2));
      for (int i = 0; i < 256; i++) begin
        imem[i] = mk(4'($urandom_range(0, 10)), 2'($urandom), 2'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_pc    = '0;
      m_carry = 1'b0;
      pulse_start();
      for (int n = 0; n < 40; n++) begin
        model_step(imem[m_pc]);
        run_to_retire("rnd", t[0]);
        check($sformatf("rnd%0d_%0d_pc", p, n), pc_o, m_pc);
        check($sformatf("rnd%0d_%0d_carry", p, n), carry_o, m_carry);
        for (int r = 0; r < 4; r++) begin
          read_reg(r, v);
          check($sformatf("rnd%0d_%0d_r%0d", p, n, r), v, m_r[r]);
        end
      end
    end
    lat = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
